seq_divider: RTL and testbench

Multi-cycle restoring divider, parametrised in WIDTH, with signed and unsigned modes and a start/busy/done handshake. It produces one quotient bit per clock and sits beside the adder, comparator and complementer blocks as the ALU's divide unit. It also reports divide-by-zero and signed overflow.

---
 rtl/seq_divider_pkg.sv | 24 ++
 rtl/carry_look_adder.sv | 36 +++
 rtl/complimenter_2.sv | 15 +
 rtl/divider_step.sv | 40 ++++
 rtl/seq_divider.sv | 147 ++++++++++++++
 tb/tb_seq_divider.sv | 244 ++++++++++++++++++++++++
 6 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and constants for the sequential divider.
//   state_t        - controller states (IDLE / ITER / FIX)
//   count_width()  - width of an iteration counter able to hold WIDTH
//   most_negative()- two's-complement most-negative pattern for a given width
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Returned 64 bits wide; callers size it down to their own width.
    function automatic logic [63:0] most_negative(input int width);
        return 64'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/carry_look_adder.sv
// carry_look_adder: WIDTH-bit adder with carries derived from generate and
// propagate terms.
//   a, b  in  WIDTH  addends
//   cin   in  1      carry in
//   sum   out WIDTH  a + b + cin (low WIDTH bits)
//   cout  out 1      carry out of the top bit
module carry_look_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    always_comb begin
        // NOTE: every always_comb target gets a full default first so no latch is inferred.
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum  = prop ^ carry[WIDTH-1:0];
    assign cout = carry[WIDTH];

endmodule

// File: rtl/complimenter_2.sv
// complimenter_2: conditional two's-complement negation.
//   value   in  WIDTH  operand
//   enable  in  1      1 = negate, 0 = pass through
//   result  out WIDTH  enable ? -value : value
module complimenter_2 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    output logic [WIDTH-1:0] result
);

    assign result = enable ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division iteration.
//   rem          in  WIDTH+1  current partial remainder
//   bit_in       in  1        next dividend bit shifted in
//   divisor_mag  in  WIDTH    divisor magnitude
//   rem_next     out WIDTH+1  partial remainder after this step
//   q_bit        out 1        quotient bit produced by this step
module divider_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           no_borrow;
    logic           unused_rem_msb;

    // The partial remainder is always below the divisor, so its top bit is
    // zero on entry and is dropped by the shift.
    assign unused_rem_msb = rem[WIDTH];
    assign shifted        = {rem[WIDTH-1:0], bit_in};

    // shifted - divisor as shifted + ~divisor + 1; a carry out means no
    // borrow, i.e. the trial remainder is non-negative.
    carry_look_adder #(.WIDTH(WIDTH + 1)) u_sub (
        .a    (shifted),
        .b    (~{1'b0, divisor_mag}),
        .cin  (1'b1),
        .sum  (trial),
        .cout (no_borrow)
    );

    assign q_bit    = no_borrow;
    assign rem_next = no_borrow ? trial : shifted;

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock,
// signed or unsigned, with start/busy/done handshake.
//   clk, reset            clock and asynchronous active-high reset
//   start                 request, sampled only when idle
//   signed_mode           1 = two's-complement operands (latched with start)
//   dividend, divisor     operands (latched with start)
//   busy                  division in progress
//   done                  one-cycle pulse when results become valid
//   quotient, remainder   registered results
//   div_by_zero, overflow flags for the last completed operation
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CNT_W   = count_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(most_negative(WIDTH));

    state_t           state;
    logic             signed_r;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             zero_div;
    logic             ovf_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] dvd_r;     // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0] dvs_r;     // divisor magnitude
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] rem_src;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    complimenter_2 #(.WIDTH(WIDTH)) u_mag_dvd (
        .value  (dividend),
        .enable (signed_mode & dividend[WIDTH-1]),
        .result (dvd_mag_in)
    );

    complimenter_2 #(.WIDTH(WIDTH)) u_mag_dvs (
        .value  (divisor),
        .enable (signed_mode & divisor[WIDTH-1]),
        .result (dvs_mag_in)
    );

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem_r),
        .bit_in      (dvd_r[WIDTH-1]),
        .divisor_mag (dvs_r),
        .rem_next    (rem_next),
        .q_bit       (q_bit)
    );

    // On divide-by-zero no iteration runs, so dvd_r still holds the dividend
    // magnitude; re-applying the dividend sign restores the original value.
    assign rem_src = zero_div ? dvd_r : rem_r[WIDTH-1:0];

    complimenter_2 #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (dvd_r),
        .enable (signed_r & (dvd_neg ^ dvs_neg)),
        .result (quo_fixed)
    );

    complimenter_2 #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (rem_src),
        .enable (signed_r & dvd_neg),
        .result (rem_fixed)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            signed_r    <= 1'b0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            zero_div    <= 1'b0;
            ovf_r       <= 1'b0;
            rem_r       <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        signed_r <= signed_mode;
                        dvd_neg  <= dividend[WIDTH-1];
                        dvs_neg  <= divisor[WIDTH-1];
                        dvd_r    <= dvd_mag_in;
                        dvs_r    <= dvs_mag_in;
                        rem_r    <= '0;
                        count    <= CNT_W'(WIDTH);
                        zero_div <= (divisor == '0);
                        ovf_r    <= signed_mode && (dividend == MIN_NEG) && (divisor == '1);
                        busy     <= 1'b1;
                        state    <= (divisor == '0) ? FIX : ITER;
                    end
                end
                ITER: begin
                    rem_r <= rem_next;
                    dvd_r <= {dvd_r[WIDTH-2:0], q_bit};
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= zero_div ? '1 : quo_fixed;
                    remainder   <= rem_fixed;
                    div_by_zero <= zero_div;
                    overflow    <= ovf_r;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed bench for seq_divider at WIDTH=8. A behavioural
// model built on integer division and a latency countdown predicts every
// output each cycle; directed vectors also check hand-computed literals.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic definition of the result: integer division truncating
    // toward zero, remainder carrying the dividend's sign.
    function automatic void model_div(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] q, output logic [W-1:0] r,
                                      output logic dbz, output logic ovf);
        int sa;
        int sb;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == '0) begin
            q   = '1;
            r   = a;
            dbz = 1'b1;
        end else if (sm) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -(2 ** (W - 1)) && sb == -1) begin
                q   = a;
                r   = '0;
                ovf = 1'b1;
            end else begin
                q = W'(sa / sb);
                r = W'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Model state: expected outputs plus a countdown of edges until done.
    logic         m_busy, m_done, m_dbz, m_ovf;
    logic [W-1:0] m_q, m_r;
    logic [W-1:0] p_q, p_r;
    logic         p_dbz, p_ovf;
    int           m_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_dbz  = 1'b0;
            m_ovf  = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_dbz  = p_dbz;
                    m_ovf  = p_ovf;
                end
            end else if (start) begin
                model_div(signed_mode, dividend, divisor, p_q, p_r, p_dbz, p_ovf);
                m_left = (divisor == '0) ? 1 : W + 1;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", busy, m_busy);
        check("cyc_done", done, m_done);
        check("cyc_quotient", quotient, m_q);
        check("cyc_remainder", remainder, m_r);
        check("cyc_div_by_zero", div_by_zero, m_dbz);
        check("cyc_overflow", overflow, m_ovf);
    end

    task automatic start_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        start       = 1'b1;
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
    endtask

    // Counts edges from the next one; lat = index of the edge after which
    // done is seen (0 = the edge that samples start).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("done_seen", lat >= 0, 1);
    endtask

    task automatic expect_results(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                                  input logic edbz, input logic eovf);
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check({name, "_dbz"}, div_by_zero, edbz);
        check({name, "_ovf"}, overflow, eovf);
    endtask

    task automatic do_div(input string name, input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input logic eovf, input int elat);
        int lat;
        @(negedge clk);
        start_op(sm, a, b);
        wait_done(lat);
        expect_results(name, eq, er, edbz, eovf);
        check({name, "_lat"}, lat, elat);
    endtask

    initial begin
        int lat;
        int pulses;
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = '0;
        divisor     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        expect_results("rst", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        do_div("u200_7",    1'b0, 8'd200, 8'd7,   8'h1C, 8'h04, 1'b0, 1'b0, W + 1);
        do_div("s_m100_7",  1'b1, 8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, W + 1);
        do_div("s100_m7",   1'b1, 8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, W + 1);
        do_div("s_m100_m7", 1'b1, 8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, W + 1);
        do_div("u55_0",     1'b0, 8'd55,  8'd0,   8'hFF, 8'h37, 1'b1, 1'b0, 1);
        do_div("s55_0",     1'b1, 8'd55,  8'd0,   8'hFF, 8'h37, 1'b1, 1'b0, 1);
        do_div("s_m100_0",  1'b1, 8'h9C,  8'd0,   8'hFF, 8'h9C, 1'b1, 1'b0, 1);
        do_div("s_ovf",     1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, W + 1);
        do_div("u80_ff",    1'b0, 8'h80,  8'hFF,  8'h00, 8'h80, 1'b0, 1'b0, W + 1);
        do_div("u255_1",    1'b0, 8'd255, 8'd1,   8'hFF, 8'h00, 1'b0, 1'b0, W + 1);
        do_div("u5_9",      1'b0, 8'd5,   8'd9,   8'h00, 8'h05, 1'b0, 1'b0, W + 1);

        // Second start during busy, with different operands, must be ignored.
        @(negedge clk);
        start_op(1'b0, 8'd200, 8'd7);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start_op(1'b1, 8'h10, 8'h03);
        @(posedge clk); #1; start = 1'b0;
        wait_done(lat);
        expect_results("ignore", 8'h1C, 8'h04, 1'b0, 1'b0);
        check("ignore_lat", lat, W + 1 - 3);

        // Start coincident with done is accepted.
        @(negedge clk);
        start_op(1'b0, 8'd100, 8'd10);
        wait_done(lat);
        expect_results("b2b_a", 8'd10, 8'h00, 1'b0, 1'b0);
        start_op(1'b1, 8'hF6, 8'd3);
        wait_done(lat);
        expect_results("b2b_b", 8'hFD, 8'hFF, 1'b0, 1'b0);
        check("b2b_lat", lat, W + 1);

        // Reset in the middle of the iterations aborts immediately.
        @(negedge clk);
        start_op(1'b0, 8'd250, 8'd3);
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        expect_results("abort", 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);

        do_div("u9_3", 1'b0, 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 1'b0, W + 1);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
